// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit micro-sequencer: decoder state codes,
// operation codes and the op-to-condition-line mapping.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0000,
        ST_DISPATCH = 4'b0001,
        ST_EXEC     = 4'b0011,
        ST_COMPLETE = 4'b1010
    } cu_state_e;

    // Op codes are {a,b}; the condition lines are {m,l,k,j}.
    localparam logic [1:0] OP_J = 2'b00;
    localparam logic [1:0] OP_K = 2'b10;
    localparam logic [1:0] OP_L = 2'b01;
    localparam logic [1:0] OP_M = 2'b11;

    function automatic logic [1:0] cond_idx(input logic [1:0] op);
        logic [1:0] idx;
        case (op)
            OP_J:    idx = 2'd0;
            OP_K:    idx = 2'd1;
            OP_L:    idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Saturating EXEC-cycle counter with synchronous clear and a terminal flag
// raised when the count reaches MAX_WAIT-1.
module cu_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(MAX_WAIT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == CNT_TERM);

endmodule

// File: rtl/cu_seq.sv
// Registered micro-sequencer feeding the control-unit decoder: drives the
// {c,d,e,f} state vector, operand select and mode from a start/op handshake.
//
// state       | meaning
// ST_IDLE     | waiting for start; outputs hold last operation's sel/mode/wait_cnt
// ST_DISPATCH | one cycle after accept; branches on captured mode
// ST_EXEC     | waiting on the selected condition line, counting non-hold cycles
// ST_COMPLETE | one-cycle done pulse, then back to idle
module cu_seq
    import cu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic [3:0]       cond,
    input  logic             hold,
    input  logic             abort,
    output logic [3:0]       st,
    output logic [1:0]       sel,
    output logic             mode_q,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] wait_cnt
);

    cu_state_e  state_q, state_d;
    logic [1:0] sel_q;
    logic       mode_r;
    logic       timeout_q;
    logic       capture;
    logic       set_timeout;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_term;

    cu_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (wait_cnt),
        .term  (cnt_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter only advances on a cycle that leaves EXEC untouched, so the
    // cycle that sees the condition (or times out) does not add to wait_cnt.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        set_timeout = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mode_r) begin
                    cnt_clr = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_COMPLETE;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_EXEC;
                end else if (cond[cond_idx(sel_q)]) begin
                    state_d = ST_COMPLETE;
                end else if (cnt_term) begin
                    set_timeout = 1'b1;
                    state_d     = ST_COMPLETE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 2'b00;
            mode_r    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                sel_q     <= op;
                mode_r    <= mode;
                timeout_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign st      = state_q;
    assign sel     = sel_q;
    assign mode_q  = mode_r;
    assign timeout = timeout_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_COMPLETE);

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq: linear stimulus with hand-computed expectations
// checked by immediate assertions one microsecond-free cycle at a time.
module tb_cu_seq;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic             mode;
    logic [3:0]       cond;
    logic             hold;
    logic             abort;
    logic [3:0]       st;
    logic [1:0]       sel;
    logic             mode_q;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cu_seq #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .mode     (mode),
        .cond     (cond),
        .hold     (hold),
        .abort    (abort),
        .st       (st),
        .sel      (sel),
        .mode_q   (mode_q),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .wait_cnt (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full visible state in one call.
    task automatic chk_all(input string tag, input logic [3:0] e_st, input logic [1:0] e_sel,
                           input logic e_mode, input logic e_done, input logic e_to,
                           input logic [CNT_W-1:0] e_cnt);
        chk({tag, ".st"},       32'(st),       32'(e_st));
        chk({tag, ".busy"},     32'(busy),     32'(e_st != 4'b0000));
        chk({tag, ".sel"},      32'(sel),      32'(e_sel));
        chk({tag, ".mode_q"},   32'(mode_q),   32'(e_mode));
        chk({tag, ".done"},     32'(done),     32'(e_done));
        chk({tag, ".timeout"},  32'(timeout),  32'(e_to));
        chk({tag, ".wait_cnt"}, 32'(wait_cnt), 32'(e_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        mode  = 1'b0;
        cond  = 4'b0000;
        hold  = 1'b0;
        abort = 1'b0;
        #1;
        chk_all("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_reset_idle", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);

        // mode 0, op K: DISPATCH, COMPLETE, IDLE
        start = 1'b1; op = 2'b10; mode = 1'b0;
        tick();
        chk_all("m0_dispatch", 4'b0001, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        tick();
        chk_all("m0_complete", 4'b1010, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        chk_all("m0_idle", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0);

        // mode 1, op M; the other condition lines are high and must be ignored
        start = 1'b1; op = 2'b11; mode = 1'b1; cond = 4'b0111;
        tick();
        chk_all("m1_dispatch", 4'b0001, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        tick();
        chk_all("m1_exec1", 4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        tick();
        chk_all("m1_exec4", 4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 8'd3);
        tick();
        chk_all("m1_exec5", 4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 8'd4);
        cond = 4'b1000;
        tick();
        chk_all("m1_complete", 4'b1010, 2'b11, 1'b1, 1'b1, 1'b0, 8'd4);
        cond = 4'b0000;
        tick();
        chk_all("m1_idle", 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 8'd4);

        // timeout: op J, condition never seen
        start = 1'b1; op = 2'b00; mode = 1'b1;
        tick();
        chk_all("to_dispatch", 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            tick();
            chk("to_exec.st", 32'(st), 32'(4'b0011));
            chk("to_exec.cnt", 32'(wait_cnt), 32'(i));
        end
        tick();
        chk_all("to_complete", 4'b1010, 2'b00, 1'b1, 1'b1, 1'b1, 8'd14);
        tick();
        chk_all("to_idle", 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 8'd14);
        tick();
        tick();
        chk("to_sticky", 32'(timeout), 32'(1'b1));

        // hold freezes the counter; start during busy is ignored
        start = 1'b1; op = 2'b01; mode = 1'b1;
        tick();
        chk_all("hold_dispatch", 4'b0001, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        tick();
        tick();
        chk_all("hold_exec2", 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);
        hold = 1'b1; start = 1'b1; op = 2'b10; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) cond = 4'b0100;
            tick();
            chk_all("hold_frozen", 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);
        end
        hold = 1'b0;
        tick();
        chk_all("hold_complete", 4'b1010, 2'b01, 1'b1, 1'b1, 1'b0, 8'd1);
        cond = 4'b0000;
        tick();
        chk_all("hold_idle", 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);
        start = 1'b0;
        tick();
        chk_all("no_queue", 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);

        // start and abort together in IDLE: nothing captured
        start = 1'b1; abort = 1'b1; op = 2'b11; mode = 1'b0;
        tick();
        chk_all("start_abort", 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);

        // abort in DISPATCH
        abort = 1'b0; op = 2'b10; mode = 1'b0;
        tick();
        chk_all("ab_disp_dispatch", 4'b0001, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b0; abort = 1'b1;
        tick();
        chk_all("ab_disp_idle", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        abort = 1'b0;
        tick();
        chk("ab_disp_nodone", 32'(done), 32'(1'b0));

        // abort in COMPLETE still pulses done
        start = 1'b1; op = 2'b00; mode = 1'b0;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        chk_all("ab_cmp_complete", 4'b1010, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        chk_all("ab_cmp_idle", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);

        // abort in EXEC
        abort = 1'b0; start = 1'b1; op = 2'b10; mode = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_all("ab_exec_exec", 4'b0011, 2'b10, 1'b1, 1'b0, 1'b0, 8'd1);
        abort = 1'b1;
        tick();
        chk_all("ab_exec_idle", 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 8'd1);
        abort = 1'b0;

        // asynchronous reset mid-EXEC at wait_cnt=5
        start = 1'b1; op = 2'b11; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_all("pre_rst_exec", 4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 8'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("after_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
